// File: rtl/io_bus_master.sv
// io_bus_master -- initiator for the 8-bit memory-mapped peripheral bus.
//
// Accepts a single-cycle request (req && ready) from the load/store unit and
// turns it into correctly timed bus strobes. Read data is returned in rdata
// together with a one-cycle done pulse. All outputs are registered.
//
// Ports:
//   clk, rst          clock (posedge) and synchronous active-high reset
//   req, op, addr,    request handshake: op 00 read, 01 write,
//   wdata             10 set-bits, 11 clear-bits; wdata is data or bit mask
//   ready, done,      idle indication, completion pulse, read result
//   rdata
//   io_address,       bus address, write data and strobes to the peripheral
//   io_din, io_w_en,
//   io_r_en
//   io_dout           registered read data from the peripheral
//
// Parameter RD_WAIT (1..15): cycles from the io_r_en cycle until io_dout is
// sampled.
//
// Optional feature macro: IO_BUS_MASTER_RMW_EN
//   defined   -> ops 10/11 are atomic read-modify-write (read, then write the
//                modified value without releasing the bus)
//   undefined -> ops 10/11 complete as a no-op one cycle after acceptance

module io_bus_master #(
  parameter int unsigned RD_WAIT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic [1:0] op,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  output logic       ready,
  output logic       done,
  output logic [7:0] rdata,
  output logic [7:0] io_address,
  output logic [7:0] io_din,
  output logic       io_w_en,
  output logic       io_r_en,
  input  logic [7:0] io_dout
);

  localparam logic [1:0] OP_RD = 2'b00;
  localparam logic [1:0] OP_WR = 2'b01;
`ifdef IO_BUS_MASTER_RMW_EN
  localparam logic [1:0] OP_SET = 2'b10;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_WAIT,
    S_DONE_NOP
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       ready_q, ready_d;
  logic       done_q, done_d;
  logic [7:0] rdata_q, rdata_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] din_q, din_d;
  logic       w_en_q, w_en_d;
  logic       r_en_q, r_en_d;
`ifdef IO_BUS_MASTER_RMW_EN
  // Latched op and mask are only needed to finish the modify-write step.
  logic [1:0] op_q, op_d;
  logic [7:0] mask_q, mask_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    addr_d  = addr_q;
    din_d   = din_q;
    w_en_d  = 1'b0;
    r_en_d  = 1'b0;
    done_d  = 1'b0;
`ifdef IO_BUS_MASTER_RMW_EN
    op_d    = op_q;
    mask_d  = mask_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req) begin
          addr_d = addr;
`ifdef IO_BUS_MASTER_RMW_EN
          op_d   = op;
          mask_d = wdata;
`endif
          if (op == OP_WR) begin
            din_d   = wdata;
            w_en_d  = 1'b1;
            state_d = S_WRITE;
          end else begin
`ifdef IO_BUS_MASTER_RMW_EN
            r_en_d  = 1'b1;
            state_d = S_READ;
`else
            if (op == OP_RD) begin
              r_en_d  = 1'b1;
              state_d = S_READ;
            end else begin
              state_d = S_DONE_NOP;
            end
`endif
          end
        end
      end
      S_WRITE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      S_READ: begin
        cnt_d   = 4'(RD_WAIT - 1);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          rdata_d = io_dout;
`ifdef IO_BUS_MASTER_RMW_EN
          if (op_q == OP_RD) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            // Modified value goes straight back out; bus stays owned.
            din_d   = (op_q == OP_SET) ? (io_dout | mask_q) : (io_dout & ~mask_q);
            w_en_d  = 1'b1;
            state_d = S_WRITE;
          end
`else
          done_d  = 1'b1;
          state_d = S_IDLE;
`endif
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DONE_NOP: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      rdata_q <= 8'h00;
      addr_q  <= 8'h00;
      din_q   <= 8'h00;
      w_en_q  <= 1'b0;
      r_en_q  <= 1'b0;
`ifdef IO_BUS_MASTER_RMW_EN
      op_q    <= 2'b00;
      mask_q  <= 8'h00;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      rdata_q <= rdata_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      w_en_q  <= w_en_d;
      r_en_q  <= r_en_d;
`ifdef IO_BUS_MASTER_RMW_EN
      op_q    <= op_d;
      mask_q  <= mask_d;
`endif
    end
  end

  assign ready      = ready_q;
  assign done       = done_q;
  assign rdata      = rdata_q;
  assign io_address = addr_q;
  assign io_din     = din_q;
  assign io_w_en    = w_en_q;
  assign io_r_en    = r_en_q;

endmodule

// File: tb/tb_io_bus_master.sv
// Directed testbench for io_bus_master: one instance at RD_WAIT=1 and one at
// RD_WAIT=3, each with a simple register-file peripheral model.
module tb_io_bus_master;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req1 = 1'b0, req3 = 1'b0;
  logic [1:0] op = 2'b00;
  logic [7:0] addr = 8'h00, wdata = 8'h00;

  logic       ready1, done1, w_en1, r_en1;
  logic [7:0] rdata1, io_addr1, io_din1, dout1;
  logic       ready3, done3, w_en3, r_en3;
  logic [7:0] rdata3, io_addr3, io_din3, dout3;

  logic [7:0] mem1 [256];
  logic [7:0] mem3 [256];
  logic [1:0] dly3;

  int n_chk = 0, n_fail = 0;
  int wcnt = 0, overlap = 0;

  always #5 clk = ~clk;

  io_bus_master #(.RD_WAIT(1)) u_dut (
    .clk(clk), .rst(rst), .req(req1), .op(op), .addr(addr), .wdata(wdata),
    .ready(ready1), .done(done1), .rdata(rdata1), .io_address(io_addr1),
    .io_din(io_din1), .io_w_en(w_en1), .io_r_en(r_en1), .io_dout(dout1)
  );

  io_bus_master #(.RD_WAIT(3)) u_dut3 (
    .clk(clk), .rst(rst), .req(req3), .op(op), .addr(addr), .wdata(wdata),
    .ready(ready3), .done(done3), .rdata(rdata3), .io_address(io_addr3),
    .io_din(io_din3), .io_w_en(w_en3), .io_r_en(r_en3), .io_dout(dout3)
  );

  // Peripheral for RD_WAIT=1: dout registered one edge after r_en.
  always @(posedge clk) begin
    if (w_en1) mem1[io_addr1] <= io_din1;
    if (r_en1) dout1 <= mem1[io_addr1];
    if (w_en1) wcnt <= wcnt + 1;
    if (w_en1 && r_en1) overlap <= overlap + 1;
  end

  // Slow peripheral: shows a stale value first, real data two edges later.
  always @(posedge clk) begin
    if (w_en3) mem3[io_addr3] <= io_din3;
    if (r_en3) begin
      dout3 <= 8'hEE;
      dly3  <= 2'd2;
    end else if (dly3 != 2'd0) begin
      dly3 <= dly3 - 2'd1;
      if (dly3 == 2'd1) dout3 <= mem3[io_addr3];
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr1(input logic [7:0] a, input logic [7:0] d);
    req1 = 1'b1; op = 2'b01; addr = a; wdata = d;
    step();
    req1 = 1'b0;
    step();
  endtask

  initial begin
    dout1 = 8'h00; dout3 = 8'h00; dly3 = 2'd0;
    step(); step();
    rst = 1'b0;
    // reset state
    check("rst_ready", ready1, 1);   check("rst_done", done1, 0);
    check("rst_rdata", rdata1, 0);   check("rst_addr", io_addr1, 0);
    check("rst_din", io_din1, 0);    check("rst_wen", w_en1, 0);
    check("rst_ren", r_en1, 0);

    // write 0x01 <- 0xA5
    req1 = 1'b1; op = 2'b01; addr = 8'h01; wdata = 8'hA5;
    step();
    req1 = 1'b0; addr = 8'h77; wdata = 8'h00;
    check("wr_wen", w_en1, 1);       check("wr_addr", io_addr1, 8'h01);
    check("wr_din", io_din1, 8'hA5); check("wr_ready", ready1, 0);
    check("wr_done0", done1, 0);
    step();
    check("wr_done", done1, 1);      check("wr_wen_off", w_en1, 0);
    check("wr_mem", mem1[1], 8'hA5); check("wr_addr_hold", io_addr1, 8'h01);
    step();
    check("wr_done_pulse", done1, 0);

    // read 0x01
    req1 = 1'b1; op = 2'b00; addr = 8'h01;
    step();
    req1 = 1'b0;
    check("rd_ren", r_en1, 1);       check("rd_wen", w_en1, 0);
    step();
    check("rd_ren_off", r_en1, 0);   check("rd_done_early", done1, 0);
    step();
    check("rd_done", done1, 1);      check("rd_rdata", rdata1, 8'hA5);
    check("rd_wcnt", wcnt, 1);

    // back-to-back: write 0x00<-0xFF, then read held on req
    req1 = 1'b1; op = 2'b01; addr = 8'h00; wdata = 8'hFF;
    step();
    op = 2'b00;
    check("bb_wen", w_en1, 1);
    step();
    check("bb_done", done1, 1);      check("bb_ignored", r_en1, 0);
    check("bb_ready", ready1, 1);
    step();
    req1 = 1'b0;
    check("bb_ren", r_en1, 1);       check("bb_done_clr", done1, 0);
    step(); step();
    check("bb_rd_done", done1, 1);   check("bb_rdata", rdata1, 8'hFF);

    // RD_WAIT=3 instance: stale then fresh data
    req3 = 1'b1; op = 2'b01; addr = 8'h10; wdata = 8'h5C;
    step();
    req3 = 1'b0;
    step();
    check("s3_wr_done", done3, 1);
    req3 = 1'b1; op = 2'b00; addr = 8'h10;
    step();
    req3 = 1'b0;
    check("s3_ren", r_en3, 1);
    step(); step(); step();
    check("s3_done_early", done3, 0);
    step();
    check("s3_done", done3, 1);      check("s3_rdata", rdata3, 8'h5C);

    // set/clear bits
    wr1(8'h02, 8'h0F);
    wr1(8'h03, 8'h0F);
    req1 = 1'b1; op = 2'b10; addr = 8'h02; wdata = 8'h30;
    step();
    req1 = 1'b0;
`ifdef IO_BUS_MASTER_RMW_EN
    check("set_ren", r_en1, 1);
    step();
    check("set_wen_early", w_en1, 0);
    step();
    check("set_wen", w_en1, 1);      check("set_din", io_din1, 8'h3F);
    check("set_rdata", rdata1, 8'h0F);
    step();
    check("set_done", done1, 1);     check("set_mem", mem1[2], 8'h3F);
`else
    check("set_ren", r_en1, 0);      check("set_wen", w_en1, 0);
    check("set_ready", ready1, 0);
    step();
    check("set_done", done1, 1);     check("set_rdata", rdata1, 8'hFF);
    check("set_mem", mem1[2], 8'h0F);
`endif
    req1 = 1'b1; op = 2'b11; addr = 8'h03; wdata = 8'h03;
    step();
    req1 = 1'b0;
`ifdef IO_BUS_MASTER_RMW_EN
    step(); step();
    check("clr_wen", w_en1, 1);      check("clr_din", io_din1, 8'h0C);
    check("clr_rdata", rdata1, 8'h0F);
    step();
    check("clr_done", done1, 1);     check("clr_mem", mem1[3], 8'h0C);
`else
    check("clr_ren", r_en1, 0);
    step();
    check("clr_done", done1, 1);     check("clr_mem", mem1[3], 8'h0F);
`endif
    step();

    // reset during WAIT of a read
    req1 = 1'b1; op = 2'b00; addr = 8'h01;
    step();
    req1 = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mr_ready", ready1, 1);    check("mr_done", done1, 0);
    check("mr_rdata", rdata1, 0);    check("mr_addr", io_addr1, 0);
    check("mr_ren", r_en1, 0);
    step();
    check("mr_no_done", done1, 0);
    wr1(8'h04, 8'h3C);
    check("mr_wr_done", done1, 1);   check("mr_wr_mem", mem1[4], 8'h3C);

    check("no_overlap", overlap, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
